// File: rtl/regfile_bist_pkg.sv
// Shared definitions for the register-file march BIST: FSM states and the
// per-address test pattern.
package regfile_bist_pkg;

  localparam int unsigned NREGS = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } state_t;

  // Address byte replicated across the word, optionally inverted for phase 1.
  function automatic logic [31:0] base(input logic [7:0] a, input logic inv);
    return {4{a}} ^ {32{inv}};
  endfunction

endpackage

// File: rtl/regfile_bist.sv
// March BIST initiator for the 2R/1W register file: write pattern, read back on
// both ports, repeat inverted; reports the first mismatch.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter bit          SKIP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_port,
  output logic [DATA_W-1:0] fail_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] i, i_n;
  logic              last, inv, accept, wr_n, rd_n;
  logic              mis, mport;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mdata;

  function automatic logic [DATA_W-1:0] expv(input logic [ADDR_W-1:0] a, input logic ph);
    if (SKIP_R0 && a == '0) return '0;
    return base(8'(a), ph);
  endfunction

  always_comb begin
    state_n = state;
    i_n     = i;
    mis     = 1'b0;
    mport   = 1'b0;
    maddr   = '0;
    mdata   = '0;
    last    = (i == '1);
    inv     = (state == WR1) || (state == RD1);
    accept  = start && ((state == IDLE) || (state == DONE));
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = WR0;
          i_n     = '0;
        end
      end
      WR0, WR1: begin
        i_n = i + 1'b1;
        if (last) state_n = (state == WR0) ? RD0 : RD1;
      end
      RD0, RD1: begin
        // Port 2 reads the mirrored address; port 1 has priority on a double miss.
        if (rf_rdata1 != expv(i, inv)) begin
          mis   = 1'b1;
          mport = 1'b0;
          maddr = i;
          mdata = rf_rdata1;
        end else if (rf_rdata2 != expv(~i, inv)) begin
          mis   = 1'b1;
          mport = 1'b1;
          maddr = ~i;
          mdata = rf_rdata2;
        end
        i_n = i + 1'b1;
        if (mis) begin
          state_n = DONE;
          i_n     = '0;
        end else if (last) begin
          state_n = (state == RD0) ? WR1 : DONE;
        end
      end
      default: begin
        state_n = IDLE;
        i_n     = '0;
      end
    endcase
    wr_n = (state_n == WR0) || (state_n == WR1);
    rd_n = (state_n == RD0) || (state_n == RD1);
  end

  // Port outputs are registered from the next-state view so they line up with i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_port <= 1'b0;
      fail_data <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
    end else begin
      state     <= state_n;
      i         <= i_n;
      busy      <= wr_n || rd_n;
      rf_we     <= wr_n && !(SKIP_R0 && i_n == '0);
      rf_waddr  <= wr_n ? i_n : '0;
      rf_wdata  <= wr_n ? base(8'(i_n), state_n == WR1) : '0;
      rf_raddr1 <= rd_n ? i_n : '0;
      rf_raddr2 <= rd_n ? ~i_n : '0;
      if (accept) begin
        done      <= 1'b0;
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_port <= 1'b0;
        fail_data <= '0;
      end else if (state_n == DONE && state != DONE) begin
        done <= 1'b1;
        pass <= !mis;
        if (mis) begin
          fail_addr <= maddr;
          fail_port <= mport;
          fail_data <= mdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: two instances (SKIP_R0=1 and 0) on behavioural register
// files with injectable faults, checked every cycle against a march-level model.
module tb_regfile_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  int   fault = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0]       bsy, dn, ps, fp, we;
  logic [1:0][4:0]  fa, wa, ra1, ra2;
  logic [1:0][31:0] fd, wd, rd1, rd2;
  logic [31:0]      mem [2][32];

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int a, input int p);
    return (32'(a) * 32'h0101_0101) ^ ((p != 0) ? 32'hFFFF_FFFF : 32'h0);
  endfunction

  function automatic bit skip(input int d);
    return d == 0;
  endfunction

  // Register-file read path with hardwired r0 and the selected fault.
  function automatic logic [31:0] rfrd(input int d, input int f, input int port,
                                       input int a, input logic [31:0] v);
    if (skip(d) && a == 0) return 32'h0;
    if (f == 1 && a == 15) return v & ~32'h8;
    if (f == 2 && port == 1 && a == 31) return 32'h0;
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    regfile_bist #(.ADDR_W(5), .DATA_W(32), .SKIP_R0(g == 0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (bsy[g]),
      .done      (dn[g]),
      .pass      (ps[g]),
      .fail_addr (fa[g]),
      .fail_port (fp[g]),
      .fail_data (fd[g]),
      .rf_we     (we[g]),
      .rf_waddr  (wa[g]),
      .rf_wdata  (wd[g]),
      .rf_raddr1 (ra1[g]),
      .rf_raddr2 (ra2[g]),
      .rf_rdata1 (rd1[g]),
      .rf_rdata2 (rd2[g])
    );
    assign rd1[g] = rfrd(g, fault, 0, int'(ra1[g]), mem[g][ra1[g]]);
    assign rd2[g] = rfrd(g, fault, 1, int'(ra2[g]), mem[g][ra2[g]]);
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (we[d]) mem[d][wa[d]] <= wd[d];
  end

  // Model state: running flag, op index k since the accepted start, end index.
  bit          r_m [2];
  int          k_m [2];
  int          e_m [2];
  bit          dn_m[2], ps_m[2], fp_m[2], pps[2], pfp[2];
  int          fa_m[2], pfa[2];
  logic [31:0] fd_m[2], pfd[2];
  logic [31:0] m   [2][32];

  task automatic plan(input int d);
    int c;
    int a;
    logic [31:0] e, v;
    c = 0;
    pps[d] = 1; pfp[d] = 0; pfa[d] = 0; pfd[d] = 0; e_m[d] = 128;
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 32; w++) begin
        c++;
        if (!(skip(d) && w == 0)) m[d][w] = pat(w, p);
      end
      for (int i = 0; i < 32; i++) begin
        c++;
        for (int port = 0; port < 2; port++) begin
          a = (port == 0) ? i : 31 - i;
          e = (skip(d) && a == 0) ? 32'h0 : pat(a, p);
          v = rfrd(d, fault, port, a, m[d][a]);
          if (v !== e) begin
            pps[d] = 0; pfp[d] = port[0]; pfa[d] = a; pfd[d] = v; e_m[d] = c;
            return;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        r_m[d] = 0; k_m[d] = 0; dn_m[d] = 0; ps_m[d] = 0;
        fp_m[d] = 0; fa_m[d] = 0; fd_m[d] = 0;
      end else if (!r_m[d]) begin
        if (start) begin
          r_m[d] = 1; k_m[d] = 0; dn_m[d] = 0; ps_m[d] = 0;
          fp_m[d] = 0; fa_m[d] = 0; fd_m[d] = 0;
          plan(d);
        end
      end else begin
        k_m[d]++;
        if (k_m[d] == e_m[d]) begin
          r_m[d] = 0; dn_m[d] = 1; ps_m[d] = pps[d];
          fp_m[d] = pfp[d]; fa_m[d] = pfa[d]; fd_m[d] = pfd[d];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input bit eb, input bit ed, input bit ep,
                         input int efa, input bit efp, input logic [31:0] efd,
                         input bit ewe, input int ewa, input logic [31:0] ewd,
                         input int er1, input int er2);
    string s;
    s = $sformatf("d%0d_", d);
    chk({s, "busy"},      32'(bsy[d]), 32'(eb));
    chk({s, "done"},      32'(dn[d]),  32'(ed));
    chk({s, "pass"},      32'(ps[d]),  32'(ep));
    chk({s, "fail_addr"}, 32'(fa[d]),  32'(efa));
    chk({s, "fail_port"}, 32'(fp[d]),  32'(efp));
    chk({s, "fail_data"}, fd[d],       efd);
    chk({s, "rf_we"},     32'(we[d]),  32'(ewe));
    chk({s, "rf_waddr"},  32'(wa[d]),  32'(ewa));
    chk({s, "rf_wdata"},  wd[d],       ewd);
    chk({s, "rf_raddr1"}, 32'(ra1[d]), 32'(er1));
    chk({s, "rf_raddr2"}, 32'(ra2[d]), 32'(er2));
  endtask

  initial forever begin
    int k, p, w;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (r_m[d]) begin
        k = k_m[d]; p = k / 64; w = k % 64;
        if (w < 32)
          cmp_dut(d, 1, 0, 0, 0, 0, 0, !(skip(d) && w == 0), w, pat(w, p), 0, 0);
        else
          cmp_dut(d, 1, 0, 0, 0, 0, 0, 0, 0, 0, w - 32, 63 - w);
      end else begin
        cmp_dut(d, 0, dn_m[d], ps_m[d], fa_m[d], fp_m[d], fd_m[d], 0, 0, 0, 0, 0);
      end
    end
    if (r_m[0] && k_m[0] == 5)  chk("wr0_a5_wdata", wd[0], 32'h0505_0505);
    if (r_m[0] && k_m[0] == 69) chk("wr1_a5_wdata", wd[0], 32'hFAFA_FAFA);
    if (r_m[0] && k_m[0] == 0)  chk("skip_r0_we", 32'(we[0]), 32'h0);
    if (r_m[1] && k_m[1] == 0)  chk("r0_wr0", {we[1], wd[1][30:0]}, 32'h8000_0000);
    if (r_m[1] && k_m[1] == 64) chk("r0_wr1", wd[1], 32'hFFFF_FFFF);
  end

  task automatic run(input int f, input int el, input int pulse_at, input int abort_at);
    int cnt, it;
    cnt = 0;
    it  = 0;
    fault = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (dn[0] !== 1'b1 && it < 400) begin
      it++;
      if (bsy[0]) cnt++;
      if (abort_at != 0 && cnt == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) cmp_dut(d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      start = (pulse_at != 0 && cnt == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_len", 32'(cnt), 32'(el));
  endtask

  initial begin
    int f, gap, el, pulse, abort;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 128, 0, 0);
    chk("clean_pass", 32'(ps[0]), 32'h1);
    chk("clean_pass_r0w", 32'(ps[1]), 32'h1);
    chk("clean_busy", 32'(bsy[0]), 32'h0);

    run(1, 48, 0, 0);
    chk("stuck_pass", 32'(ps[0]), 32'h0);
    chk("stuck_addr", 32'(fa[0]), 32'd15);
    chk("stuck_port", 32'(fp[0]), 32'h0);
    chk("stuck_data", fd[0], 32'h0F0F_0F07);

    run(2, 33, 0, 0);
    chk("p2_addr", 32'(fa[0]), 32'd31);
    chk("p2_port", 32'(fp[0]), 32'h1);
    chk("p2_data", fd[0], 32'h0);

    run(0, 128, 10, 0);
    chk("restart_pass", 32'(ps[0]), 32'h1);

    run(0, 0, 0, 40);
    run(0, 128, 0, 0);
    chk("post_reset_pass", 32'(ps[0]), 32'h1);

    for (int r = 0; r < 8; r++) begin
      f   = int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 4));
      repeat (gap) @(negedge clk);
      el    = (f == 0) ? 128 : (f == 1) ? 48 : 33;
      pulse = int'($urandom_range(1, el - 2));
      abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, el - 1)) : 0;
      run(f, el, pulse, abort);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
Name: regfile_bist

Overview:
Built-in self-test initiator for the 32x32 two-read/one-write register file. It drives the regfile write port and both read ports through a fixed march: write a pattern, read it back on both ports, then repeat with the inverted pattern. It reports pass/fail plus the first failing address, port and data. It sits beside `regfile`, muxed onto its ports during test.

Parameters:
ADDR_W, 5, regfile address width; NREGS = 2**ADDR_W
DATA_W, 32, regfile data width; fixed at 32 because the pattern definition depends on it
SKIP_R0, 1, 1 = register 0 is hardwired zero: never written, expected to read 0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a test; sampled only in IDLE or DONE
busy  out  1  high while a test is running
done  out  1  level; high in DONE until the next accepted start
pass  out  1  valid while done=1; 1 = no mismatch
fail_addr  out  ADDR_W  address of the first mismatch
fail_port  out  1  0 = rdata1, 1 = rdata2
fail_data  out  DATA_W  observed data at the first mismatch
rf_we  out  1  regfile write enable
rf_waddr  out  ADDR_W  regfile write address
rf_wdata  out  DATA_W  regfile write data
rf_raddr1  out  ADDR_W  regfile read address, port 1
rf_raddr2  out  ADDR_W  regfile read address, port 2
rf_rdata1  in  DATA_W  regfile read data, port 1 (combinational read)
rf_rdata2  in  DATA_W  regfile read data, port 2 (combinational read)

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; every output = 0, including rf_we. Reset takes effect immediately, including mid-test.
- Pattern: base(a) = {4{3'b000,a}}, e.g. base(5)=32'h0505_0505. Phase 0 uses base(a); phase 1 uses ~base(a).
- Expected read value exp(a): 0 if a==0 and SKIP_R0=1; otherwise the current phase's pattern.
- States and transitions:
  - IDLE -> WR0 on start.
  - WR0 -> RD0 -> WR1 -> RD1 -> DONE.
  - Any RD state -> DONE immediately on a mismatch.
  - DONE -> WR0 on start; this clears done, pass and the fail_* outputs.
- WRx state:
  - Counter i runs 0..NREGS-1, one address per cycle.
  - rf_waddr=i, rf_wdata=pattern(i).
  - rf_we=1, except rf_we=0 when i==0 and SKIP_R0=1.
- RDx state:
  - Counter i runs 0..NREGS-1, one cycle each; rf_raddr1=i, rf_raddr2=NREGS-1-i.
  - Both rdata inputs are compared against exp() in the same cycle; the result is registered at the closing edge.
  - If both ports mismatch in the same cycle, port 1 wins.
  - Capture on mismatch: fail_addr, fail_port, fail_data.
- All rf_* outputs are registered. rf_we=0 and addresses=0 outside WR/RD states.
- Counter wraps NREGS-1 -> 0 exactly at each phase change. No idle cycle between phases.
- Timing: start sampled at edge E0. WR0 covers cycles 1..32. A clean run ends with done=1, pass=1, busy=0 after edge E0+4*NREGS (edge 128); busy=1 on edges 1..128.
- Early exit: after a mismatch, done=1 and pass=0 on the next edge.
- start while busy is ignored.

Decomposition:
- regfile_bist_pkg: state enum (IDLE, WR0, RD0, WR1, RD1, DONE), pattern function base(a, inv), NREGS constant.
- No sub-module. The counter, FSM and compare fit in one module of about 150-200 lines.

Test Plan:
- Clean run: bench wires regfile_bist to a healthy `regfile` and pulses start.
  - busy high for 128 cycles; done=1, pass=1.
  - WR0 at waddr 5: rf_wdata=32'h0505_0505. WR1 at waddr 5: rf_wdata=32'hFAFA_FAFA.
- Stuck-bit fault: regfile model forces bit 3 of reg 15 to 0.
  - Fails in RD0 at i=15: pass=0, fail_addr=15, fail_port=0, fail_data=32'h0F0F_0F07.
  - done rises one edge after that read.
- Port-2-only fault: only rdata2 is corrupted for reg 31, forced to 0.
  - Fails at RD0 i=0: fail_port=1, fail_addr=31, fail_data=0.
- R0 handling:
  - SKIP_R0=1: rf_we=0 when waddr=0; reads of reg 0 expect 0; pass=1.
  - SKIP_R0=0: reg 0 written with 0, then 32'hFFFF_FFFF.
- Reset mid-test: drop rst_n at cycle 40 (RD0).
  - All outputs 0 immediately, rf_we=0.
  - After release, start -> a full clean run with pass=1.
- Start handling:
  - start pulsed during busy: ignored, run length unchanged.
  - start in DONE: done and pass clear on the next edge and a new run begins.
